fpga_rst_seq: RTL



---
 rtl/fpga_rst_pkg.sv | 27 ++
 rtl/fpga_sync_ff.sv | 34 +++
 rtl/fpga_rst_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fpga_rst_pkg.sv
// ============================================================================
//  Module      : fpga_rst_pkg
//  Description : Shared types and constants for the FPGA board reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpga_rst_pkg;

    typedef enum logic [1:0] {
        S_HOLD     = 2'd0,
        S_RUN      = 2'd1,
        S_WAIT_REL = 2'd2
    } state_e;

    localparam logic [1:0] RST_CAUSE_POR = 2'b00;
    localparam logic [1:0] RST_CAUSE_BTN = 2'b01;
    localparam logic [1:0] RST_CAUSE_WDT = 2'b10;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpga_sync_ff.sv
// ============================================================================
//  Module      : fpga_sync_ff
//  Description : N-stage single-bit synchronizer, async active-high reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpga_sync_ff
    import fpga_rst_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/fpga_rst_seq.sv
// ============================================================================
//  Module      : fpga_rst_seq
//  Description : Board reset sequencer: debounced button, stretched SoC reset,
//                reset-cause capture. Optional watchdog with FPGA_RST_WDT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpga_rst_seq
    import fpga_rst_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int HOLD_CYC     = 1024,
    parameter int WDT_CYC      = 2**24
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_rst_n_i,
    input  logic       wdt_kick_i,
    output logic       soc_rst_n_o,
    output logic [1:0] rst_cause_o
);

    localparam int DEB_W  = cnt_width(DEBOUNCE_CYC);
    localparam int HOLD_W = cnt_width(HOLD_CYC);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    logic              w_rst_rel;
    logic              w_rst;
    logic              w_btn_s;
    logic              w_wdt_expire;
    logic              w_leave_run;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              btn_deb_q, btn_deb_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    state_e            state_q;
    logic              soc_rst_n_q;
    logic [1:0]        cause_q;

    // Assertion follows rst_i at once through the flop's async clear.
    fpga_sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_rst_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (1'b1),
        .q_o   (w_rst_rel)
    );
    assign w_rst = ~w_rst_rel;

    fpga_sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_btn_sync (
        .clk_i (clk_i),
        .rst_i (w_rst),
        .d_i   (btn_rst_n_i),
        .q_o   (w_btn_s)
    );

    always_comb begin
        deb_cnt_d = '0;
        btn_deb_d = btn_deb_q;
        if (w_btn_s != btn_deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                btn_deb_d = w_btn_s;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge w_rst) begin
        if (w_rst) begin
            deb_cnt_q <= '0;
            btn_deb_q <= 1'b1;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            btn_deb_q <= btn_deb_d;
        end
    end

    assign w_leave_run = (state_q == S_RUN) && (!btn_deb_q || w_wdt_expire);

`ifdef FPGA_RST_WDT_EN
    localparam int WDT_W = cnt_width(WDT_CYC);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYC - 1);

    logic             w_kick_s;
    logic             w_kick_edge;
    logic             kick_prev_q;
    logic             wdt_armed_q;
    logic [WDT_W-1:0] wdt_cnt_q;

    fpga_sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_kick_sync (
        .clk_i (clk_i),
        .rst_i (w_rst),
        .d_i   (wdt_kick_i),
        .q_o   (w_kick_s)
    );

    assign w_kick_edge  = w_kick_s ^ kick_prev_q;
    assign w_wdt_expire = wdt_armed_q && (wdt_cnt_q == WDT_LAST) && !w_kick_edge;

    always_ff @(posedge clk_i or posedge w_rst) begin
        if (w_rst) begin
            kick_prev_q <= 1'b0;
            wdt_armed_q <= 1'b0;
            wdt_cnt_q   <= '0;
        end else begin
            kick_prev_q <= w_kick_s;
            if ((state_q != S_RUN) || w_leave_run) begin
                wdt_armed_q <= 1'b0;
                wdt_cnt_q   <= '0;
            end else if (w_kick_edge) begin
                wdt_armed_q <= 1'b1;
                wdt_cnt_q   <= '0;
            end else if (wdt_armed_q) begin
                wdt_cnt_q   <= wdt_cnt_q + 1'b1;
            end
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = wdt_kick_i & (WDT_CYC != 0);
    assign w_wdt_expire = 1'b0;
`endif

    // Button is checked first so a coincident press takes priority over expiry.
    always_ff @(posedge clk_i or posedge w_rst) begin
        if (w_rst) begin
            state_q     <= S_HOLD;
            hold_cnt_q  <= '0;
            soc_rst_n_q <= 1'b0;
            cause_q     <= RST_CAUSE_POR;
        end else begin
            hold_cnt_q <= '0;
            case (state_q)
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        if (!btn_deb_q) begin
                            state_q     <= S_WAIT_REL;
                            soc_rst_n_q <= 1'b0;
                        end else begin
                            state_q     <= S_RUN;
                            soc_rst_n_q <= 1'b1;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!btn_deb_q) begin
                        state_q     <= S_WAIT_REL;
                        soc_rst_n_q <= 1'b0;
                        cause_q     <= RST_CAUSE_BTN;
                    end else if (w_wdt_expire) begin
                        state_q     <= S_HOLD;
                        soc_rst_n_q <= 1'b0;
                        cause_q     <= RST_CAUSE_WDT;
                    end
                end
                S_WAIT_REL: begin
                    if (btn_deb_q) begin
                        state_q <= S_HOLD;
                    end
                end
                default: begin
                    state_q     <= S_HOLD;
                    soc_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign soc_rst_n_o = soc_rst_n_q;
    assign rst_cause_o = cause_q;

endmodule

`default_nettype wire
